// File: rtl/switch_mcu_seq.sv
// rtl/switch_mcu_seq.sv - RV32I OP/OP-IMM fetch/decode sequencer with a 5-cycle execute window
//
// Fetches one instruction at a time, decodes it into a one-hot ALU enable
// and register/immediate fields, then walks out_cycle_cnt through 1..5 so
// the downstream ALU units can key their register-file read/write actions.
// The sequencer owns the PC.
//
// Optional feature macro: SWITCH_MCU_SEQ_ILLEGAL_TRAP_EN
//   defined   : an illegal instruction halts the sequencer (only reset exits)
//   undefined : an illegal instruction runs as a NOP; out_illegal tied to 0
//
// Ports:
//   in_clk, in_rst       clock, asynchronous active-low reset
//   in_run               allow fetching; low parks in IDLE after current WB
//   out_imem_req/addr    fetch request (held through FETCH) and address (= PC)
//   in_imem_ack/rdata    single-cycle ack with the instruction word
//   out_cycle_cnt        0 outside execute, 1..5 during execute/writeback
//   out_op_en            one-hot ALU enable (19 ops)
//   out_imm_type_i, out_rs1, out_rs2, out_rd   decoded fields
//   out_pc               current PC
//   out_illegal          illegal-instruction flag
module switch_mcu_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_run,
    output logic        out_imem_req,
    output logic [31:0] out_imem_addr,
    input  logic        in_imem_ack,
    input  logic [31:0] in_imem_rdata,
    output logic [3:0]  out_cycle_cnt,
    output logic [18:0] out_op_en,
    output logic [11:0] out_imm_type_i,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic [3:0]  cnt_q;
    logic [18:0] op_en_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [18:0] op_en_d;
    logic        legal_d;

    // Combinational decode of the word arriving with the ack; it is only
    // captured on the ack edge, so it never needs to be held here.
    logic [6:0] dec_opcode;
    logic [2:0] dec_funct3;
    logic [6:0] dec_funct7;

    assign dec_opcode = in_imem_rdata[6:0];
    assign dec_funct3 = in_imem_rdata[14:12];
    assign dec_funct7 = in_imem_rdata[31:25];

    always_comb begin
        op_en_d = '0;
        case (dec_opcode)
            7'b0010011: begin
                case (dec_funct3)
                    3'b000: op_en_d[0] = 1'b1;
                    3'b010: op_en_d[1] = 1'b1;
                    3'b011: op_en_d[2] = 1'b1;
                    3'b100: op_en_d[3] = 1'b1;
                    3'b110: op_en_d[4] = 1'b1;
                    3'b111: op_en_d[5] = 1'b1;
                    3'b001: op_en_d[6] = (dec_funct7 == 7'b0000000);
                    3'b101: begin
                        op_en_d[7] = (dec_funct7 == 7'b0000000);
                        op_en_d[8] = (dec_funct7 == 7'b0100000);
                    end
                    default: ;
                endcase
            end
            7'b0110011: begin
                if (dec_funct7 == 7'b0000000) begin
                    case (dec_funct3)
                        3'b000: op_en_d[9]  = 1'b1;
                        3'b001: op_en_d[11] = 1'b1;
                        3'b010: op_en_d[12] = 1'b1;
                        3'b011: op_en_d[13] = 1'b1;
                        3'b100: op_en_d[14] = 1'b1;
                        3'b101: op_en_d[15] = 1'b1;
                        3'b110: op_en_d[17] = 1'b1;
                        3'b111: op_en_d[18] = 1'b1;
                        default: ;
                    endcase
                end else if (dec_funct7 == 7'b0100000) begin
                    // Only sub and sra use the alternate funct7.
                    op_en_d[10] = (dec_funct3 == 3'b000);
                    op_en_d[16] = (dec_funct3 == 3'b101);
                end
            end
            default: ;
        endcase
    end

    assign legal_d = |op_en_d;

`ifdef SWITCH_MCU_SEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign out_illegal = illegal_q;
`else
    assign out_illegal = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            cnt_q   <= 4'd0;
            op_en_q <= '0;
            instr_q <= '0;
            pc_q    <= RESET_PC;
`ifdef SWITCH_MCU_SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_run) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (in_imem_ack) begin
                        req_q   <= 1'b0;
                        instr_q <= in_imem_rdata;
`ifdef SWITCH_MCU_SEQ_ILLEGAL_TRAP_EN
                        if (!legal_d) begin
                            // PC stays on the offending address for debug.
                            state_q   <= S_HALT;
                            illegal_q <= 1'b1;
                        end else begin
                            state_q <= S_EXEC;
                            cnt_q   <= 4'd1;
                            op_en_q <= op_en_d;
                        end
`else
                        // Illegal words decode to all-zero enables: a NOP.
                        state_q <= S_EXEC;
                        cnt_q   <= 4'd1;
                        op_en_q <= op_en_d;
`endif
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd4) begin
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    cnt_q   <= 4'd0;
                    op_en_q <= '0;
                    pc_q    <= pc_q + 32'd4;
                    if (in_run) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_imem_req   = req_q;
    assign out_imem_addr  = pc_q;
    assign out_pc         = pc_q;
    assign out_cycle_cnt  = cnt_q;
    assign out_op_en      = op_en_q;
    assign out_imm_type_i = instr_q[31:20];
    assign out_rs1        = instr_q[19:15];
    assign out_rs2        = instr_q[24:20];
    assign out_rd         = instr_q[11:7];

endmodule

// File: tb/tb_switch_mcu_seq.sv
// tb/tb_switch_mcu_seq.sv - scoreboard testbench for switch_mcu_seq
module tb_switch_mcu_seq;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
`ifdef SWITCH_MCU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_run = 1'b0;
    logic        out_imem_req;
    logic [31:0] out_imem_addr;
    logic        in_imem_ack = 1'b0;
    logic [31:0] in_imem_rdata = '0;
    logic [3:0]  out_cycle_cnt;
    logic [18:0] out_op_en;
    logic [11:0] out_imm_type_i;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_pc;
    logic        out_illegal;

    switch_mcu_seq #(.RESET_PC(RST_PC)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_run(in_run),
        .out_imem_req(out_imem_req), .out_imem_addr(out_imem_addr),
        .in_imem_ack(in_imem_ack), .in_imem_rdata(in_imem_rdata),
        .out_cycle_cnt(out_cycle_cnt), .out_op_en(out_op_en),
        .out_imm_type_i(out_imm_type_i), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [18:0] op_en;
        logic [11:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_pc = RST_PC;
    bit          mon_en = 1'b1;
    int          prev_cnt = 0;

    // Architectural tables: OP-IMM funct3 -> op index, OP funct3 -> op index (funct7=0).
    int imm_tab[8] = '{0, 6, 1, 2, 3, 7, 4, 5};
    int reg_tab[8] = '{9, 11, 12, 13, 14, 15, 17, 18};
    // Generator tables: op index -> funct3.
    int gen_f3[19] = '{0, 2, 3, 4, 6, 7, 1, 5, 5, 0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Reference decode straight from the ISA field rules; -1 means illegal.
    function automatic int ref_op(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        if (w[6:0] == 7'h13) begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? 6 : -1;
            if (f3 == 3'd5) return (f7 == 7'h00) ? 7 : (f7 == 7'h20) ? 8 : -1;
            return imm_tab[f3];
        end
        if (w[6:0] == 7'h33) begin
            if (f7 == 7'h00) return reg_tab[f3];
            if (f7 == 7'h20 && f3 == 3'd0) return 10;
            if (f7 == 7'h20 && f3 == 3'd5) return 16;
        end
        return -1;
    endfunction

    function automatic logic [31:0] make_instr(input int idx);
        logic [31:0] w;
        logic [6:0]  f7;
        w = $urandom;
        if (idx >= 19) begin
            // Illegal: either a non-ALU opcode or OP with an M-extension funct7.
            if ($urandom_range(0, 1) == 0) w[6:0] = 7'b0110111;
            else begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
            return w;
        end
        w[14:12] = 3'(gen_f3[idx]);
        if (idx <= 8) begin
            w[6:0] = 7'h13;
            if (idx == 6 || idx == 7) w[31:25] = 7'h00;
            if (idx == 8) w[31:25] = 7'h20;
        end else begin
            w[6:0] = 7'h33;
            f7 = (idx == 10 || idx == 16) ? 7'h20 : 7'h00;
            w[31:25] = f7;
        end
        return w;
    endfunction

    task automatic pulse_reset();
        mon_en = 1'b0;
        @(negedge in_clk);
        in_rst = 1'b0;
        #1;
        check("rst_req", out_imem_req, 1'b0);
        check("rst_cnt", out_cycle_cnt, 4'd0);
        check("rst_op_en", out_op_en, 19'd0);
        check("rst_pc", out_pc, RST_PC);
        check("rst_addr", out_imem_addr, RST_PC);
        check("rst_illegal", out_illegal, 1'b0);
        exp_q.delete();
        exp_pc = RST_PC;
        @(negedge in_clk);
        in_rst = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic issue(input logic [31:0] w, input int dly, input bit stray);
        int   t;
        int   idx;
        bit   trap_ill;
        exp_t e;
        t = 0;
        while (!out_imem_req && t < 100) begin @(negedge in_clk); t++; end
        if (!out_imem_req) begin
            check("fetch_timeout", 1'b0, 1'b1);
            return;
        end
        check("fetch_addr", out_imem_addr, exp_pc);
        for (int i = 0; i < dly; i++) begin
            @(negedge in_clk);
            check("fetch_hold", {out_imem_req, out_cycle_cnt}, {1'b1, 4'd0});
        end
        idx = ref_op(w);
        trap_ill = TRAP && (idx < 0);
        if (!trap_ill) begin
            e.op_en = (idx < 0) ? 19'd0 : (19'd1 << idx);
            e.imm   = w[31:20];
            e.rs1   = w[19:15];
            e.rs2   = w[24:20];
            e.rd    = w[11:7];
            e.pc    = exp_pc;
            exp_q.push_back(e);
        end
        in_imem_rdata = w;
        in_imem_ack   = 1'b1;
        @(negedge in_clk);
        in_imem_ack = 1'b0;
        if (trap_ill) begin
            check("halt_illegal", out_illegal, 1'b1);
            check("halt_op_en", out_op_en, 19'd0);
            check("halt_cnt", out_cycle_cnt, 4'd0);
            repeat (8) @(negedge in_clk);
            check("halt_no_req", out_imem_req, 1'b0);
            check("halt_pc", out_pc, exp_pc);
            pulse_reset();
        end else begin
            exp_pc = exp_pc + 32'd4;
            if (stray) begin
                @(negedge in_clk);
                in_imem_rdata = $urandom;
                in_imem_ack   = 1'b1;
                @(negedge in_clk);
                in_imem_ack = 1'b0;
            end
        end
    endtask

    // Monitor: pops an expectation whenever an execute window opens and
    // follows it through writeback.
    always @(negedge in_clk) begin
        if (!mon_en || !in_rst) begin
            prev_cnt = 0;
        end else begin
            if (prev_cnt == 0 && out_cycle_cnt == 4'd1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_exec", 1'b1, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    check("dec_op_en", out_op_en, cur.op_en);
                    check("dec_fields", {out_rd, out_rs1, out_rs2, out_imm_type_i},
                          {cur.rd, cur.rs1, cur.rs2, cur.imm});
                    check("exec_pc", out_pc, cur.pc);
                    check("exec_req_low", out_imem_req, 1'b0);
                end
            end else if (prev_cnt >= 1 && prev_cnt <= 4) begin
                check("cnt_step", out_cycle_cnt, 32'(prev_cnt + 1));
                check("hold_op_en", out_op_en, cur.op_en);
                check("hold_fields", {out_rd, out_rs1, out_rs2, out_imm_type_i},
                      {cur.rd, cur.rs1, cur.rs2, cur.imm});
            end else if (prev_cnt == 5) begin
                check("wb_cnt_zero", out_cycle_cnt, 4'd0);
                check("wb_pc", out_pc, cur.pc + 32'd4);
                check("wb_req", out_imem_req, in_run);
            end
            prev_cnt = int'(out_cycle_cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int idx;
        in_rst = 1'b0;
        repeat (3) @(negedge in_clk);
        check("reset_req", out_imem_req, 1'b0);
        check("reset_pc", out_pc, RST_PC);
        check("reset_addr", out_imem_addr, RST_PC);
        check("reset_outs", {out_cycle_cnt, out_illegal, out_rd, out_rs1, out_rs2},
              32'd0);
        check("reset_op_imm", {out_op_en, out_imm_type_i}, 32'd0);
        in_rst = 1'b1;
        @(negedge in_clk);
        check("idle_no_req", out_imem_req, 1'b0);
        in_run = 1'b1;
        @(negedge in_clk);
        check("first_req", out_imem_req, 1'b1);
        check("first_addr", out_imem_addr, RST_PC);

        // srai x5,x3,4 with immediate ack
        issue(32'h4041D293, 0, 1'b0);
        check("srai_op_en", out_op_en, 19'h00100);
        check("srai_imm", out_imm_type_i, 12'h404);
        // addi x1,x0,5 with 3-cycle fetch wait
        issue(32'h00500093, 3, 1'b0);
        // slli with nonzero imm[11:5]
        issue(32'h40419293, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 21);
            issue(make_instr(idx), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        // Reset during the execute window
        issue(make_instr(9), 0, 1'b0);
        begin
            int t = 0;
            while (out_cycle_cnt != 4'd3 && t < 20) begin @(negedge in_clk); t++; end
            check("reach_cnt3", out_cycle_cnt, 4'd3);
        end
        pulse_reset();

        issue(make_instr(8), 0, 1'b0);
        in_run = 1'b0;
        repeat (10) @(negedge in_clk);
        check("park_idle_req", out_imem_req, 1'b0);
        check("park_idle_cnt", out_cycle_cnt, 4'd0);
        check("park_pc", out_pc, exp_pc);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_mcu_seq.md
# switch_mcu_seq

Instruction sequencer/decoder for the switch MCU core. It fetches one RV32I OP/OP-IMM instruction at a time from instruction memory and decodes it into a one-hot ALU enable plus register and immediate fields. It then steps the shared cycle counter through the fixed 5-cycle execute/writeback window that every ALU unit (e.g. the SRAI unit) keys its register-file read and write actions on. It sits directly upstream of all ALU units and owns the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- in_clk  input  1  core clock; all state on rising edge.
- in_rst  input  1  asynchronous, active-low reset.
- in_run  input  1  high allows fetching; low parks the sequencer in IDLE after the current instruction.
- out_imem_req  output  1  fetch request, held high throughout FETCH.
- out_imem_addr  output  32  fetch address (= PC).
- in_imem_ack  input  1  single-cycle acknowledge; in_imem_rdata is valid in the same cycle.
- in_imem_rdata  input  32  instruction word.
- out_cycle_cnt  output  4  0 outside execute; 1..5 during execute/writeback. Drives ALU in_cycle_cnt.
- out_op_en  output  19  one-hot ALU enable. Bit order: 0 addi, 1 slti, 2 sltiu, 3 xori, 4 ori, 5 andi, 6 slli, 7 srli, 8 srai, 9 add, 10 sub, 11 sll, 12 slt, 13 sltu, 14 xor, 15 srl, 16 sra, 17 or, 18 and.
- out_imm_type_i  output  12  instr[31:20].
- out_rs1  output  5  instr[19:15].
- out_rs2  output  5  instr[24:20].
- out_rd  output  5  instr[11:7].
- out_pc  output  32  current PC.
- out_illegal  output  1  illegal-instruction flag (see Configuration).

## Operation
- States: IDLE, FETCH, EXEC (cnt 1..4), WB (cnt 5), HALT.
- IDLE: in_run=1 → FETCH.
- FETCH: request the instruction at out_pc. On in_imem_ack, latch and decode in_imem_rdata, then → EXEC with cnt=1. Without an ack, stay in FETCH indefinitely.
- Decode, opcode 0010011 (OP-IMM): funct3 selects the op.
  - slli requires imm[11:5]=0000000.
  - funct3=101 with imm[11:5]=0000000 → srli; with 0100000 → srai.
- Decode, opcode 0110011 (OP): funct7 0000000/0100000 with funct3 selects the op. 0100000 is valid only for sub and sra.
- Any other encoding is illegal: out_op_en=0.
- EXEC: cnt increments 1→4, then → WB.
- Fields and out_op_en are held stable for cnt 1..5.
- WB (cnt=5): ALU writeback lands. PC += 4, wrapping modulo 2^32. Next state is FETCH if in_run=1, else IDLE.
- in_run deasserted mid-instruction has no effect until WB.
- Reset asserted at any time, including mid-fetch or mid-execute: immediate return to the reset state. The in-flight instruction is abandoned, and no partial PC update occurs.

## Timing
- Reset values:
  - state IDLE, out_pc=RESET_PC, out_imem_addr=RESET_PC.
  - all other outputs 0.
- All outputs are registered.
- Ack at edge N: out_cycle_cnt=1, out_op_en and fields valid from edge N.
- cnt=5 at edge N+4; PC updated and out_imem_req high at edge N+5.
- Instruction period = 5 cycles + fetch wait cycles. The minimum is 6 cycles, with an ack in the first FETCH cycle.
- out_imem_req drops at the ack edge.
- An ack outside FETCH is ignored.

## Configuration
- SWITCH_MCU_SEQ_ILLEGAL_TRAP_EN defined:
  - An illegal instruction → HALT at the ack edge. out_illegal=1, out_op_en=0, out_cycle_cnt=0.
  - out_pc holds the offending address and no fetch is issued.
  - Only reset exits HALT.
- Undefined:
  - An illegal instruction executes as a NOP: cnt walks 1..5 with out_op_en=0, then PC += 4.
  - out_illegal is tied to 0.

## Test plan
- Reset, then in_run=1 → out_imem_req=1 with addr=RESET_PC, all other outputs 0.
- Fetch 0x4041D293 (srai x5,x3,4) with ack at cycle 0 → out_op_en=19'h00100 (bit 8); imm=12'h404, rs1=3, rd=5; cnt 1..5 over cycles 0..4; PC=RESET_PC+4 at cycle 5.
- Fetch 0x00500093 (addi x1,x0,5) with ack delayed 3 cycles → FETCH held 3 extra cycles, then out_op_en bit 0, imm=5, rd=1.
- Fetch 0x40419293 (slli with imm[11:5]≠0):
  - with macro: out_illegal=1, out_pc unchanged, no further req.
  - without macro: NOP and PC += 4.
- PC=32'hFFFF_FFFC, then complete one instruction → PC wraps to 0.
- Reset asserted at cnt=3 → all outputs 0 and PC=RESET_PC within the same cycle; normal fetch after release.
